// File: rtl/serial_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator: one SLICE-bit digit per clock through an equal/greater cascade.
// Optional build macro EARLY_EXIT_EN: finish as soon as the first differing digit decides the result.
module serial_mag_comparator #(
  parameter int WIDTH  = 8,
  parameter int SLICE  = 1,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int S  = WIDTH / SLICE;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(S - 1);
  // Flipping the sign bit maps two's complement onto offset binary, so the unsigned cascade orders signed values.
  localparam logic [WIDTH-1:0] MSB_FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_last;
  logic [CW-1:0]    r_cnt;
  logic             r_e;
  logic             r_g;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [SLICE-1:0] w_a_d;
  logic [SLICE-1:0] w_b_d;
  logic             w_e_upd;
  logic             w_g_upd;

  assign w_a_d   = r_a[WIDTH-1 -: SLICE];
  assign w_b_d   = r_b[WIDTH-1 -: SLICE];
  assign w_e_upd = r_e & (w_a_d == w_b_d);
  assign w_g_upd = r_g | (r_e & (w_a_d > w_b_d));

`ifdef EARLY_EXIT_EN
  assign w_last = (r_cnt == '0) | ~w_e_upd;
`else
  assign w_last = (r_cnt == '0);
`endif

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_g     <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_cnt <= CNT_INIT;
        r_e   <= 1'b1;
        r_g   <= 1'b0;
        r_eq  <= 1'b0;
        r_gt  <= 1'b0;
        r_lt  <= 1'b0;
      end else if (r_state == RUN) begin
        r_e <= w_e_upd;
        r_g <= w_g_upd;
        if (w_last) begin
          r_eq <= w_e_upd;
          r_gt <= w_g_upd;
          r_lt <= ~w_e_upd & ~w_g_upd;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  // Operand shift registers carry no reset; they are reloaded on every accepted start.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_a <= a ^ MSB_FLIP;
      r_b <= b ^ MSB_FLIP;
    end else if (r_state == RUN) begin
      r_a <= r_a << SLICE;
      r_b <= r_b << SLICE;
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign eq   = r_eq;
  assign gt   = r_gt;
  assign lt   = r_lt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator: unsigned 8x1, signed 8x1 and unsigned 8x4 instances.
module tb_serial_mag_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, s_start, f_start;
  logic [7:0] a, b, s_a, s_b, f_a, f_b;
  logic       busy, done, eq, gt, lt;
  logic       s_busy, s_done, s_eq, s_gt, s_lt;
  logic       f_busy, f_done, f_eq, f_gt, f_lt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit prev_done = 1'b0;

  typedef struct {
    logic [2:0] res;
    int         cyc;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] sq[$];
  exp_t       mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_mag_comparator #(.WIDTH(8), .SLICE(1), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt));

  serial_mag_comparator #(.WIDTH(8), .SLICE(1), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .eq(s_eq), .gt(s_gt), .lt(s_lt));

  serial_mag_comparator #(.WIDTH(8), .SLICE(4), .SIGNED(0)) dut_f (
    .clk(clk), .rst(rst), .start(f_start), .a(f_a), .b(f_b),
    .busy(f_busy), .done(f_done), .eq(f_eq), .gt(f_gt), .lt(f_lt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ordering {eq,gt,lt} straight from integer comparison.
  function automatic logic [2:0] model(input logic [7:0] x, input logic [7:0] y, input bit sgn);
    if (sgn) begin
      if ($signed(x) == $signed(y)) return 3'b100;
      if ($signed(x) >  $signed(y)) return 3'b010;
      return 3'b001;
    end
    if (x == y) return 3'b100;
    if (x > y)  return 3'b010;
    return 3'b001;
  endfunction

  // Edges from accept to the edge entering DONE.
  function automatic int lat(input logic [7:0] x, input logic [7:0] y, input int slice);
    int s;
    logic [7:0] d;
    logic [7:0] mask;
    s    = 8 / slice;
    d    = 8'h00;
    mask = 8'((1 << slice) - 1);
`ifdef EARLY_EXIT_EN
    for (int i = 0; i < s; i++) begin
      d = (x ^ y) >> (8 - (i + 1) * slice);
      if ((d & mask) != 8'h00) return i + 1;
    end
`endif
    return s;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      chk("done_overlap", {31'b0, prev_done}, 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_res"}, {29'b0, eq, gt, lt}, {29'b0, mon_e.res});
        chk({mon_e.tag, "_lat"}, cyc, mon_e.cyc);
      end
    end
    prev_done = done;
  end

  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input string tag);
    exp_t e;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    e.res = model(x, y, 1'b0);
    e.cyc = cyc + 1 + lat(x, y, 1);
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    chk({tag, "_busy"}, {31'b0, busy}, 1);
    chk({tag, "_clr"}, {29'b0, eq, gt, lt}, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("idle_timeout", 32'(sb.size()) + {31'b0, busy}, 0);
  endtask

  task automatic run_side(input bit four, input logic [7:0] x, input logic [7:0] y,
                          input logic [2:0] er, input int el, input string tag);
    int n;
    logic [2:0] r;
    sq.push_back(er);
    @(negedge clk);
    if (four) begin f_a = x; f_b = y; f_start = 1'b1; end
    else      begin s_a = x; s_b = y; s_start = 1'b1; end
    @(negedge clk);
    f_start = 1'b0; s_start = 1'b0;
    n = 0;
    while (!(four ? f_done : s_done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    r = four ? {f_eq, f_gt, f_lt} : {s_eq, s_gt, s_lt};
    chk({tag, "_lat"}, n, el);
    chk({tag, "_res"}, {29'b0, r}, {29'b0, sq.pop_front()});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nxt;
    int l;
    logic [7:0] x, y;
    exp_t e;

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    s_start = 1'b0; s_a = 8'h00; s_b = 8'h00;
    f_start = 1'b0; f_a = 8'h00; f_b = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_main", {27'b0, busy, done, eq, gt, lt}, 0);
    chk("reset_side", {22'b0, s_busy, s_done, s_eq, s_gt, s_lt, f_busy, f_done, f_eq, f_gt, f_lt}, 0);
    rst = 1'b0;

    start_op(8'hA5, 8'hA5, "eq_a5");
    n = 0;
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("eq_a5_busy_cycles", n, 9);
    wait_idle();

    start_op(8'h80, 8'h7F, "gt_msb");
    wait_idle();
    chk("gt_hold", {29'b0, eq, gt, lt}, 3'b010);
    repeat (3) @(negedge clk);
    chk("gt_hold_late", {29'b0, eq, gt, lt}, 3'b010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_clears", {27'b0, busy, done, eq, gt, lt}, 0);

    start_op(8'h80, 8'h00, "gt_early"); wait_idle();
    start_op(8'h00, 8'hFF, "lt_zero");  wait_idle();
    start_op(8'hFF, 8'hFE, "gt_lsb");   wait_idle();
    start_op(8'h3C, 8'h3D, "lt_lsb");   wait_idle();
    start_op(8'h7F, 8'h80, "lt_msb");   wait_idle();

    // Reset lands on edge k+4 while the equal-operand compare is still scanning.
    start_op(8'h5A, 8'h5A, "rst_mid");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", {27'b0, busy, done, eq, gt, lt}, 0);
    sb.delete();
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_mid_idle", {31'b0, busy}, 0);
    start_op(8'h12, 8'h34, "after_rst"); wait_idle();

    // start held high with fresh operands every cycle; only accepted operands may matter.
    nxt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) nxt = cyc + 1;
      x = 8'($urandom);
      y = (i % 3 == 0) ? x : 8'($urandom);
      a = x; b = y; start = 1'b1;
      if (cyc + 1 == nxt) begin
        l = lat(x, y, 1);
        e.res = model(x, y, 1'b0);
        e.cyc = cyc + 1 + l;
        e.tag = "hold_start";
        sb.push_back(e);
        nxt = cyc + 1 + l + 2;
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    run_side(1'b0, 8'h80, 8'h7F, model(8'h80, 8'h7F, 1'b1), lat(8'h80, 8'h7F, 1), "s_min_vs_max");
    run_side(1'b0, 8'hFF, 8'h01, model(8'hFF, 8'h01, 1'b1), lat(8'hFF, 8'h01, 1), "s_neg1_vs_1");
    run_side(1'b0, 8'hFE, 8'hFD, model(8'hFE, 8'hFD, 1'b1), lat(8'hFE, 8'hFD, 1), "s_neg_gt");
    run_side(1'b1, 8'h3C, 8'h3D, 3'b001, 2, "f_3c_3d");
    run_side(1'b1, 8'hC3, 8'h3C, model(8'hC3, 8'h3C, 1'b0), lat(8'hC3, 8'h3C, 4), "f_gt");
    run_side(1'b1, 8'h69, 8'h69, 3'b100, 2, "f_eq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
